// File: rtl/lfsr_burst_ctrl.sv
// lfsr_burst_ctrl
//   Burst sequencer for a single XNOR-feedback LFSR. It accepts {seed, length}
//   commands, loads the seed into the LFSR, then streams exactly `length` words
//   on a valid/ready port. The LFSR advances only on accepted beats. This block
//   is the only driver of the LFSR enable and seed ports.
//
//   Optional feature macro: LFSR_CTRL_WRAP_CNT_EN
//     defined   : o_Wrap_Cnt counts beats after the first on which the LFSR is
//                 back at its seed. It saturates at 255, is cleared on command
//                 accept and holds its value after the burst.
//     undefined : o_Wrap_Cnt is tied to 0.
//
// Ports
//   i_Clk, i_Rst        clock, synchronous active-high reset
//   i_Cmd_DV/Seed/Len   command input; accepted when i_Cmd_DV & o_Cmd_Ready
//   o_Cmd_Ready         high in idle, except in the cycle a done pulse is shown
//   o_Cmd_Err           1-cycle pulse when a command carries the lock-up seed
//   i_Abort             terminate the running burst
//   o_Data, o_DV        stream output; i_Ready is the stream ready
//   o_Burst_Done        1-cycle pulse when a burst ends
//   o_Burst_Aborted     qualifies o_Burst_Done: the burst was ended by i_Abort
//   o_Wrap_Cnt          LFSR wrap counter (see macro above)
//   o_LFSR_*            drive the LFSR enable, seed-valid and seed-data inputs
//   i_LFSR_Data/Done    LFSR state and "state == seed" flag

module lfsr_burst_ctrl #(
   parameter int unsigned NUM_BITS = 5,
   parameter int unsigned LEN_BITS = 16
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   input  logic                i_Cmd_DV,
   input  logic [NUM_BITS-1:0] i_Cmd_Seed,
   input  logic [LEN_BITS-1:0] i_Cmd_Len,
   output logic                o_Cmd_Ready,
   output logic                o_Cmd_Err,
   input  logic                i_Abort,
   output logic [NUM_BITS-1:0] o_Data,
   output logic                o_DV,
   input  logic                i_Ready,
   output logic                o_Burst_Done,
   output logic                o_Burst_Aborted,
   output logic [7:0]          o_Wrap_Cnt,
   output logic                o_LFSR_Enable,
   output logic                o_LFSR_Seed_DV,
   output logic [NUM_BITS-1:0] o_LFSR_Seed_Data,
   input  logic [NUM_BITS-1:0] i_LFSR_Data,
   input  logic                i_LFSR_Done
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

   state_e              state_q, state_d;
   logic [NUM_BITS-1:0] seed_q, seed_d;
   logic [LEN_BITS-1:0] len_q, len_d;
   logic [LEN_BITS-1:0] cnt_q, cnt_d;
   logic                cmd_err_q, cmd_err_d;
   logic                done_q, done_d;
   logic                aborted_q, aborted_d;

   logic cmd_accept;
   logic beat;
   logic last_beat;

   assign cmd_accept = i_Cmd_DV & o_Cmd_Ready;
   assign beat       = (state_q == StRun) & i_Ready;
   // Len is never 0 in RUN, so cnt_q + 1 cannot overflow before it matches.
   assign last_beat  = beat & ((cnt_q + LEN_BITS'(1)) == len_q);

   // State register
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and status-pulse registers
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         seed_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         cmd_err_q <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         seed_q    <= seed_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         cmd_err_q <= cmd_err_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      seed_d    = seed_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      cmd_err_d = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cmd_accept) begin
               if (&i_Cmd_Seed) begin
                  // All-ones is the XNOR lock-up state; the LFSR would never move.
                  cmd_err_d = 1'b1;
               end else if (i_Cmd_Len == '0) begin
                  done_d = 1'b1;
               end else begin
                  seed_d  = i_Cmd_Seed;
                  len_d   = i_Cmd_Len;
                  cnt_d   = '0;
                  state_d = StLoad;
               end
            end
         end
         StLoad: begin
            if (i_Abort) begin
               state_d   = StIdle;
               done_d    = 1'b1;
               aborted_d = 1'b1;
            end else begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (beat) begin
               cnt_d = cnt_q + LEN_BITS'(1);
            end
            // Abort takes priority over a coincident final beat.
            if (i_Abort) begin
               state_d   = StIdle;
               done_d    = 1'b1;
               aborted_d = 1'b1;
            end else if (last_beat) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output decode
   always_comb begin
      o_Cmd_Ready    = 1'b0;
      o_DV           = 1'b0;
      o_LFSR_Enable  = 1'b0;
      o_LFSR_Seed_DV = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Do not take a new command while the previous done pulse is showing.
            o_Cmd_Ready = ~done_q;
         end
         StLoad: begin
            o_LFSR_Enable  = 1'b1;
            o_LFSR_Seed_DV = 1'b1;
         end
         StRun: begin
            o_DV          = 1'b1;
            o_LFSR_Enable = i_Ready;
         end
         default: ;
      endcase
   end

   assign o_Data           = i_LFSR_Data;
   assign o_LFSR_Seed_Data = seed_q;
   assign o_Cmd_Err        = cmd_err_q;
   assign o_Burst_Done     = done_q;
   assign o_Burst_Aborted  = aborted_q;

`ifdef LFSR_CTRL_WRAP_CNT_EN
   logic [7:0] wrap_q;

   // The first beat always shows the seed, so it is not counted as a wrap.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         wrap_q <= '0;
      end else if (cmd_accept) begin
         wrap_q <= '0;
      end else if (beat && (cnt_q != '0) && i_LFSR_Done && (wrap_q != 8'hFF)) begin
         wrap_q <= wrap_q + 8'd1;
      end
   end

   assign o_Wrap_Cnt = wrap_q;
`else
   logic unused_lfsr_done;
   assign unused_lfsr_done = i_LFSR_Done;
   assign o_Wrap_Cnt       = '0;
`endif

endmodule
